// File: rtl/libstd.sv
// -----------------------------------------------------------------------------
// libstd
//   Shared constants and helper functions for the serial/debug codebase.
//
//   ASCII_CR / ASCII_LF : line-ending characters used by text formatters.
//   log2x(n)            : ceil(log2(n)), with log2x(1) = 0. Used to size
//                         pointers and occupancy counters from a depth.
// -----------------------------------------------------------------------------
package libstd;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic int unsigned log2x(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with distributed-RAM storage. The head entry is read
//   asynchronously from the read pointer, so it is valid whenever empty is low.
//   Occupancy is tracked in a dedicated count register (0..DEPTH); full and
//   empty are decoded from it, which keeps the pointers at log2(DEPTH) bits.
//
//   Parameters
//     DEPTH : number of entries, power of two, >= 2
//     WIDTH : entry width in bits
//
//   Ports
//     clk   : clock
//     rst   : synchronous active-high reset (empties the FIFO)
//     clr   : synchronous clear; same effect as rst, wins over push/pop
//     push  : write wdata at the tail (ignored when full)
//     pop   : discard the head entry (ignored when empty)
//     wdata : data to write
//     head  : current head entry (undefined when empty)
//     full  : count == DEPTH
//     empty : count == 0
//     count : number of stored entries
// -----------------------------------------------------------------------------
module sync_fifo
    import libstd::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        head,
    output logic                    full,
    output logic                    empty,
    output logic [log2x(DEPTH):0]   count
);

    localparam int unsigned AW = log2x(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;
    logic             wipe;

    assign wipe    = rst || clr;
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full  && !wipe;
    assign pop_ok  = pop  && !empty && !wipe;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wipe) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally modulo DEPTH through truncation.
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // Storage carries no reset: contents are only observed through count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/rs232_tx_buf.sv
// -----------------------------------------------------------------------------
// rs232_tx_buf
//   Byte buffer and line-ending formatter in front of the serial transmit
//   controller. Bytes from core-side logic are queued in a sync_fifo and
//   drained through the transmitter's rdy/val byte interface. With CRLF=1
//   every LF (0x0A) leaves as CR LF (0x0D 0x0A); the LF stays at the FIFO head
//   while its CR is sent, so level counts an expanded LF once.
//
//   Parameters
//     DEPTH : FIFO entries, power of two, >= 2
//     CRLF  : 1 = expand LF into CR LF, 0 = pass bytes unchanged
//
//   Ports
//     clk     : clock
//     rst     : synchronous active-high reset
//     flush   : synchronous discard of all buffered bytes (and a pending LF)
//     in_val  : upstream byte valid
//     in_rdy  : buffer can accept a byte (registered state, rst, flush only)
//     in_data : upstream byte
//     tx_rdy  : transmitter ready, single-cycle pulses
//     tx_val  : byte available for transmitter (registered state only)
//     tx_bits : byte presented to transmitter (registered state only)
//     level   : number of buffered entries
// -----------------------------------------------------------------------------
module rs232_tx_buf
    import libstd::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CRLF  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [7:0]              in_data,
    input  logic                    tx_rdy,
    output logic                    tx_val,
    output logic [7:0]              tx_bits,
    output logic [log2x(DEPTH):0]   level
);

    typedef enum logic {
        S_DATA = 1'b0,
        S_LF   = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       push;
    logic       pop;
    logic       expand_lf;

    // No bypass path: a byte is only visible to the transmitter once stored.
    assign in_rdy    = !fifo_full && !rst && !flush;
    assign push      = in_val && in_rdy;
    assign expand_lf = (CRLF != 0) && (fifo_head == ASCII_LF);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (level)
    );

    always_comb begin
        state_d = state_q;
        tx_val  = 1'b0;
        tx_bits = fifo_head;
        pop     = 1'b0;
        case (state_q)
            S_DATA: begin
                tx_val = !fifo_empty;
                if (expand_lf) begin
                    // Send CR first; the LF stays queued until S_LF sends it.
                    tx_bits = ASCII_CR;
                    if (!fifo_empty && tx_rdy) begin
                        state_d = S_LF;
                    end
                end else begin
                    tx_bits = fifo_head;
                    pop     = !fifo_empty && tx_rdy;
                end
            end
            S_LF: begin
                tx_val  = 1'b1;
                tx_bits = ASCII_LF;
                if (tx_rdy) begin
                    pop     = 1'b1;
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_DATA;
            end
        endcase
    end

    // flush drops a pending LF; the transmitter already holds the CR.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= S_DATA;
        end else begin
            state_q <= state_d;
        end
    end

`ifndef SYNTHESIS
    in_data_stable_a : assert property (
        @(posedge clk) disable iff (rst)
        (in_val && !in_rdy) |=> (!in_val || $stable(in_data))
    );
`endif

endmodule

// File: doc/rs232_tx_buf.md
Name: rs232_tx_buf

Overview:
Byte buffer and line-ending formatter directly upstream of the serial transmit controller. Accepts bytes from debug/LCD logic at core clock rate. Holds them in a small synchronous FIFO and drains them into the transmitter's rdy/val byte interface at line rate. Optionally expands LF (0x0A) into CR LF (0x0D 0x0A) so terminals render correctly.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
CRLF, 1, 1 = expand each 0x0A into 0x0D then 0x0A; 0 = pass bytes unchanged.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
flush  input  1  synchronous discard of all buffered bytes
in_val  input  1  upstream byte valid
in_rdy  output  1  buffer can accept a byte
in_data  input  8  upstream byte
tx_rdy  input  1  transmitter ready; combinational from transmitter, high single cycles
tx_val  output  1  byte available for transmitter
tx_bits  output  8  byte presented to transmitter
level  output  log2x(DEPTH)+1  number of buffered entries (a pending expanded LF counts once)

Behaviour:
- Handshakes:
  - Push when in_val && in_rdy at the clock edge.
  - Transmitter transfer when tx_val && tx_rdy at the clock edge.
  - tx_val and tx_bits depend only on registered state, never on tx_rdy.
  - in_rdy depends only on registered state, never on in_val.
- Reset (rst high): FIFO empties, state S_DATA, level 0, tx_val 0, in_rdy 0. The cycle after rst deasserts: in_rdy 1.
- in_rdy = !full && !rst && !flush.
- No bypass. A push into an empty FIFO raises tx_val on the next cycle (1-cycle latency). When full, in_rdy stays 0 even if a pop occurs in the same cycle.
- Simultaneous push and pop while neither empty nor full: level unchanged, both complete.
- Pointers: rd/wr pointers are log2x(DEPTH) bits and wrap modulo DEPTH. Full/empty come from a separate count register (0..DEPTH); level = count.
- Output state machine (two states):
  - S_DATA:
    - tx_val = !empty.
    - If CRLF && head==0x0A: tx_bits = 0x0D. On transfer go to S_LF; do not pop.
    - Otherwise: tx_bits = head. On transfer pop; stay in S_DATA.
  - S_LF:
    - tx_val = 1, tx_bits = 0x0A.
    - On transfer pop the head and return to S_DATA.
- With CRLF=0, S_LF is unreachable.
- flush (priority below rst, above all else): count := 0, pointers := 0, state := S_DATA, tx_val 0 next cycle. Any push or pop in the same cycle is ignored.
- flush or rst while in S_LF: the pending 0x0A is discarded. Transmitter framing is unaffected because it already latched 0x0D.
- tx_rdy high while tx_val low has no effect.
- Sim only (translate_off): assertion that in_data is stable while in_val && !in_rdy.

Decomposition:
- Shared package libstd: ASCII_CR = 8'h0D and ASCII_LF = 8'h0A constants; the log2x function already lives there.
- Enumerated typedef for S_DATA/S_LF is local to the module.
- One natural sub-module: sync_fifo (DEPTH, WIDTH=8; push/pop/full/empty/count/head, synchronous clear input). Storage is distributed RAM; head is read asynchronously from rd pointer.
- rs232_tx_buf adds the CRLF state machine and handshake glue around it.

Test Plan:
- Reset then idle: after rst, in_rdy=1, tx_val=0, level=0. Push 0x41 at cycle 0 -> tx_val=1, tx_bits=0x41 at cycle 1, level=1. Pulse tx_rdy -> level=0, tx_val=0 next cycle.
- CRLF=1, push 0x48,0x0A,0x49; tx_rdy pulses every 10 cycles -> transmitter sees 0x48,0x0D,0x0A,0x49 in order. level drops 3->2 after 0x48, stays 2 after 0x0D, drops to 1 after 0x0A.
- CRLF=0, same stimulus -> sequence 0x48,0x0A,0x49 exactly.
- Fill with DEPTH=16 bytes 0x00..0x0F, tx_rdy held low -> in_rdy=0, level=16. Hold in_val with 0x10 while pulsing tx_rdy once -> 0x10 accepted only the cycle after the pop; drain yields 0x00..0x10 in order, with pointer wrap exercised.
- Concurrent push/pop at level 5 -> level stays 5 and order is preserved.
- CRLF=1, head 0x0A, transfer 0x0D, then assert flush -> tx_val=0, level=0 next cycle, no 0x0A emitted. A subsequent push of 0x55 transmits 0x55 from S_DATA.
